nanorv32_dbg_ctrl: RTL

Debug run-control sequencer for the nanorv32 core. It consumes the debug control registers held by the VIC APB register block (stepping enable, breakpoint-0 enable, breakpoint addresses). It compares them against the core's issue stage and blocks instruction issue. It drains the pipeline, reports the halt and its cause, and handles resume, so breakpoints and single-stepping actually stop and restart the CPU.

---
 rtl/nanorv32_dbg_pkg.sv | 23 ++
 rtl/nanorv32_dbg_bkpt_cmp.sv | 29 ++
 rtl/nanorv32_dbg_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/nanorv32_dbg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nanorv32_dbg_pkg
// Purpose  : Shared definitions for the nanorv32 debug run-control
//            sequencer: FSM state encoding and halt cause codes.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package nanorv32_dbg_pkg;

  typedef enum logic [1:0] {
    DBG_RUN    = 2'd0,
    DBG_DRAIN  = 2'd1,
    DBG_HALTED = 2'd2
  } dbg_state_e;

  localparam logic [1:0] DBG_CAUSE_NONE  = 2'd0;
  localparam logic [1:0] DBG_CAUSE_BKPT0 = 2'd1;
  localparam logic [1:0] DBG_CAUSE_BKPT1 = 2'd2;
  localparam logic [1:0] DBG_CAUSE_STEP  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/nanorv32_dbg_bkpt_cmp.sv
`default_nettype none
// ============================================================================
// Module   : nanorv32_dbg_bkpt_cmp
// Purpose  : Single breakpoint comparator. Matches a halfword-aligned
//            instruction PC against a breakpoint address; bit 0 of both
//            operands is ignored.
// Ports    : enable  in  1   comparator enable
//            addr    in  32  breakpoint address
//            pc      in  32  issue-stage PC
//            hit     out 1   enable & address match
// Revision : 1.0 - initial release
// ============================================================================
module nanorv32_dbg_bkpt_cmp
  import nanorv32_dbg_pkg::*;
(
  input  logic        enable,
  input  logic [31:0] addr,
  input  logic [31:0] pc,
  output logic        hit
);

  // Bit 0 carries no address information (instructions are halfword aligned).
  logic unused_lsb;
  assign unused_lsb = addr[0] ^ pc[0];

  assign hit = enable & (pc[31:1] == addr[31:1]);

endmodule
`default_nettype wire

// File: rtl/nanorv32_dbg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nanorv32_dbg_ctrl
// Purpose  : Debug run-control sequencer. Blocks issue on a breakpoint hit
//            or after a single step, drains the pipeline, reports the halt
//            and its cause, and returns to RUN on a resume pulse.
// Config   : NANORV32_DBG_BKPT1_EN - when defined, builds the breakpoint-1
//            comparator; otherwise hit1 is tied low and bkpt1_addr_r unused.
// Ports    : clk_apb             in  1   clock
//            rst_apb_n           in  1   async active-low reset
//            dbgctrl_stepping_r  in  1   step mode
//            dbgctrl_bkp0_r      in  1   breakpoint 0 enable
//            bkpt0_addr_r        in  32  breakpoint 0 address
//            bkpt1_addr_r        in  32  breakpoint 1 address, bit0 = enable
//            cpu_issue_valid     in  1   issue stage valid
//            cpu_issue_pc        in  32  issue stage PC
//            cpu_pipe_empty      in  1   nothing in flight past issue
//            dbg_resume_req      in  1   resume pulse
//            dbg_issue_block     out 1   combinational issue block
//            dbg_halt_req        out 1   DRAIN or HALTED
//            dbg_halted          out 1   HALTED
//            dbg_cause           out 2   halt cause
//            dbg_halt_irq        out 1   one-cycle pulse on HALTED entry
// Revision : 1.0 - initial release
// ============================================================================
module nanorv32_dbg_ctrl
  import nanorv32_dbg_pkg::*;
(
  input  logic        clk_apb,
  input  logic        rst_apb_n,
  input  logic        dbgctrl_stepping_r,
  input  logic        dbgctrl_bkp0_r,
  input  logic [31:0] bkpt0_addr_r,
  input  logic [31:0] bkpt1_addr_r,
  input  logic        cpu_issue_valid,
  input  logic [31:0] cpu_issue_pc,
  input  logic        cpu_pipe_empty,
  input  logic        dbg_resume_req,
  output logic        dbg_issue_block,
  output logic        dbg_halt_req,
  output logic        dbg_halted,
  output logic [1:0]  dbg_cause,
  output logic        dbg_halt_irq
);

  dbg_state_e state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic       skip_q, skip_d;
  logic       halt_req_q, halted_q, halt_irq_q, halt_irq_d;

  logic cmp0_hit, cmp1_hit;
  logic hit0, hit1;
  logic hit_counted;
  logic issue_block;

  nanorv32_dbg_bkpt_cmp u_bkpt0_cmp (
    .enable (dbgctrl_bkp0_r),
    .addr   (bkpt0_addr_r),
    .pc     (cpu_issue_pc),
    .hit    (cmp0_hit)
  );

`ifdef NANORV32_DBG_BKPT1_EN
  nanorv32_dbg_bkpt_cmp u_bkpt1_cmp (
    .enable (bkpt1_addr_r[0]),
    .addr   (bkpt1_addr_r),
    .pc     (cpu_issue_pc),
    .hit    (cmp1_hit)
  );
`else
  logic [31:0] unused_bkpt1;
  assign unused_bkpt1 = bkpt1_addr_r;
  assign cmp1_hit     = 1'b0;
`endif

  assign hit0 = cpu_issue_valid & cmp0_hit;
  assign hit1 = cpu_issue_valid & cmp1_hit;
  // Right after a resume the instruction sitting on the breakpoint must be
  // allowed through once, so hits are masked until the next issue fire.
  assign hit_counted = ~skip_q & (hit0 | hit1);

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    skip_d      = skip_q;
    halt_irq_d  = 1'b0;
    issue_block = 1'b0;
    case (state_q)
      DBG_RUN: begin
        if (hit_counted) begin
          // Block in the same cycle so the breakpointed instruction never issues.
          issue_block = 1'b1;
          state_d     = DBG_DRAIN;
          cause_d     = hit0 ? DBG_CAUSE_BKPT0 : DBG_CAUSE_BKPT1;
        end else if (cpu_issue_valid) begin
          // Issue fires here; a step lets this instruction complete first.
          skip_d = 1'b0;
          if (dbgctrl_stepping_r) begin
            state_d = DBG_DRAIN;
            cause_d = DBG_CAUSE_STEP;
          end
        end
      end
      DBG_DRAIN: begin
        issue_block = 1'b1;
        if (cpu_pipe_empty) begin
          state_d    = DBG_HALTED;
          halt_irq_d = 1'b1;
        end
      end
      DBG_HALTED: begin
        issue_block = 1'b1;
        if (dbg_resume_req) begin
          state_d = DBG_RUN;
          cause_d = DBG_CAUSE_NONE;
          skip_d  = 1'b1;
        end
      end
      default: begin
        state_d = DBG_RUN;
      end
    endcase
  end

  always_ff @(posedge clk_apb or negedge rst_apb_n) begin
    if (!rst_apb_n) begin
      state_q    <= DBG_RUN;
      cause_q    <= DBG_CAUSE_NONE;
      skip_q     <= 1'b0;
      halt_req_q <= 1'b0;
      halted_q   <= 1'b0;
      halt_irq_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      skip_q     <= skip_d;
      halt_req_q <= (state_d != DBG_RUN);
      halted_q   <= (state_d == DBG_HALTED);
      halt_irq_q <= halt_irq_d;
    end
  end

  assign dbg_issue_block = issue_block;
  assign dbg_halt_req    = halt_req_q;
  assign dbg_halted      = halted_q;
  assign dbg_cause       = cause_q;
  assign dbg_halt_irq    = halt_irq_q;

endmodule
`default_nettype wire
